hack_cpu_ctrl: RTL and testbench

Multi-cycle Hack CPU control and register stage that sits directly around the 16-bit Hack ALU. It fetches instructions over a req/ack handshake, holds the A, D and PC registers, and drives the ALU operands and the six control bits. It captures the ALU result and flags, writes back to A, D or data memory, and resolves jumps. The ALU is an external combinational block: this stage both feeds it and consumes its output in the same cycle.

---
 rtl/hack_pkg.sv | 35 +++
 rtl/hack_jump_unit.sv | 11 +
 rtl/hack_cpu_ctrl.sv | 132 +++++++++++++
 tb/tb_hack_cpu_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// Shared definitions for the Hack CPU control stage: FSM states,
// instruction field positions and the ALU control bundle.
package hack_pkg;

    localparam int HACK_PC_W = 15;
    localparam int HACK_W    = 16;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_RD,
        S_EXEC,
        S_MEM_WR
    } state_t;

    localparam int IR_CI      = 15;
    localparam int IR_A       = 12;
    localparam int IR_COMP_HI = 11;
    localparam int IR_COMP_LO = 6;
    localparam int IR_D1      = 5;
    localparam int IR_D2      = 4;
    localparam int IR_D3      = 3;
    localparam int IR_JMP_HI  = 2;
    localparam int IR_JMP_LO  = 0;

    typedef struct packed {
        logic zx;
        logic nx;
        logic zy;
        logic ny;
        logic f;
        logic no;
    } alu_ctrl_t;

endpackage

// File: rtl/hack_jump_unit.sv
// Hack jump condition: j[2]=lt, j[1]=eq, j[0]=gt, evaluated on the ALU flags.
module hack_jump_unit (
    input  logic [2:0] j,
    input  logic       zr,
    input  logic       ng,
    output logic       take
);

    assign take = (j[2] & ng) | (j[1] & zr) | (j[0] & ~ng & ~zr);

endmodule

// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle Hack CPU control/register stage wrapped around an external
// combinational ALU; fetches over req/ack and writes back to A, D or memory.
module hack_cpu_ctrl
    import hack_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    output logic                 imem_req,
    output logic [HACK_PC_W-1:0] imem_addr,
    input  logic                 imem_ack,
    input  logic [HACK_W-1:0]    imem_data,
    output logic                 dmem_rd_req,
    output logic                 dmem_wr_req,
    output logic [HACK_PC_W-1:0] dmem_addr,
    output logic [HACK_W-1:0]    dmem_wdata,
    input  logic                 dmem_ack,
    input  logic [HACK_W-1:0]    dmem_rdata,
    output logic [HACK_W-1:0]    alu_x,
    output logic [HACK_W-1:0]    alu_y,
    output logic [5:0]           alu_ctrl,
    input  logic [HACK_W-1:0]    alu_out,
    input  logic                 alu_zr,
    input  logic                 alu_ng,
    output logic [HACK_PC_W-1:0] pc,
    output logic [HACK_W-1:0]    a_reg,
    output logic [HACK_W-1:0]    d_reg,
    output logic                 retire
);

    state_t                 state;
    state_t                 state_nxt;
    logic [HACK_W-1:0]      ir;
    logic [HACK_W-1:0]      m_reg;
    logic [HACK_PC_W-1:0]   waddr;
    logic                   fetch_pend;
    logic                   take;
    logic [HACK_PC_W-1:0]   pc_inc;
    alu_ctrl_t              ctrl;

    assign pc_inc    = pc + 15'd1;
    assign imem_addr = pc;
    assign ctrl      = alu_ctrl_t'(ir[IR_COMP_HI:IR_COMP_LO]);
    assign alu_ctrl  = ctrl;
    assign alu_x     = d_reg;
    assign alu_y     = ir[IR_A] ? m_reg : a_reg;
    // Reads address through live A; writes use the A captured in EXEC.
    assign dmem_addr = (state == S_MEM_WR) ? waddr : a_reg[HACK_PC_W-1:0];

    hack_jump_unit u_jump (
        .j    (ir[IR_JMP_HI:IR_JMP_LO]),
        .zr   (alu_zr),
        .ng   (alu_ng),
        .take (take)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:  if (imem_req && imem_ack) state_nxt = S_DECODE;
            S_DECODE: begin
                if (!ir[IR_CI])    state_nxt = S_FETCH;
                else if (ir[IR_A]) state_nxt = S_MEM_RD;
                else               state_nxt = S_EXEC;
            end
            S_MEM_RD: if (dmem_ack) state_nxt = S_EXEC;
            S_EXEC:   state_nxt = ir[IR_D3] ? S_MEM_WR : S_FETCH;
            S_MEM_WR: if (dmem_ack) state_nxt = S_FETCH;
            default:  state_nxt = S_FETCH;
        endcase
    end

    // The fetch request is gated by rst_n so it drops while reset is held even if run is high.
    always_comb begin
        imem_req    = 1'b0;
        dmem_rd_req = 1'b0;
        dmem_wr_req = 1'b0;
        retire      = 1'b0;
        case (state)
            S_FETCH:  imem_req    = rst_n & (run | fetch_pend);
            S_DECODE: retire      = ~ir[IR_CI];
            S_MEM_RD: dmem_rd_req = 1'b1;
            S_EXEC:   retire      = ~ir[IR_D3];
            S_MEM_WR: begin
                dmem_wr_req = 1'b1;
                retire      = dmem_ack;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pend <= 1'b0;
            ir         <= '0;
            m_reg      <= '0;
            a_reg      <= '0;
            d_reg      <= '0;
            pc         <= '0;
            waddr      <= '0;
            dmem_wdata <= '0;
        end else begin
            fetch_pend <= imem_req & ~imem_ack;
            case (state)
                S_FETCH: if (imem_req && imem_ack) ir <= imem_data;
                S_DECODE: begin
                    if (!ir[IR_CI]) begin
                        a_reg <= {1'b0, ir[14:0]};
                        pc    <= pc_inc;
                    end
                end
                S_MEM_RD: if (dmem_ack) m_reg <= dmem_rdata;
                S_EXEC: begin
                    if (ir[IR_D1]) a_reg <= alu_out;
                    if (ir[IR_D2]) d_reg <= alu_out;
                    pc <= take ? a_reg[HACK_PC_W-1:0] : pc_inc;
                    if (ir[IR_D3]) begin
                        dmem_wdata <= alu_out;
                        waddr      <= a_reg[HACK_PC_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Directed bench for hack_cpu_ctrl with a Hack ALU model, a zero-wait ROM
// and a data memory whose ack latency is programmable per test.
module tb_hack_cpu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        imem_req;
    logic [14:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic        dmem_rd_req;
    logic        dmem_wr_req;
    logic [14:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic        dmem_ack;
    logic [15:0] dmem_rdata;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic [5:0]  alu_ctrl;
    logic [15:0] alu_out;
    logic        alu_zr;
    logic        alu_ng;
    logic [14:0] pc;
    logic [15:0] a_reg;
    logic [15:0] d_reg;
    logic        retire;

    logic [15:0] rom [64];
    logic [15:0] dmem [128];
    int          dmem_lat = 0;
    int          lat_cnt = 0;
    int          wr_cnt = 0;
    int          rd_cycles = 0;
    logic [14:0] last_waddr = '0;
    logic [15:0] last_wdata = '0;
    logic        excl_bad = 1'b0;

    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    hack_cpu_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .dmem_rd_req (dmem_rd_req),
        .dmem_wr_req (dmem_wr_req),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_ack    (dmem_ack),
        .dmem_rdata  (dmem_rdata),
        .alu_x       (alu_x),
        .alu_y       (alu_y),
        .alu_ctrl    (alu_ctrl),
        .alu_out     (alu_out),
        .alu_zr      (alu_zr),
        .alu_ng      (alu_ng),
        .pc          (pc),
        .a_reg       (a_reg),
        .d_reg       (d_reg),
        .retire      (retire)
    );

    function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                             input logic [5:0] c);
        logic [15:0] xx, yy, o;
        xx = c[5] ? 16'h0 : x;
        xx = c[4] ? ~xx : xx;
        yy = c[3] ? 16'h0 : y;
        yy = c[2] ? ~yy : yy;
        o  = c[1] ? (xx + yy) : (xx & yy);
        return c[0] ? ~o : o;
    endfunction

    always_comb begin
        alu_out = hack_alu(alu_x, alu_y, alu_ctrl);
        alu_zr  = (alu_out == 16'h0);
        alu_ng  = alu_out[15];
    end

    assign imem_ack   = imem_req;
    assign imem_data  = rom[imem_addr[5:0]];
    assign dmem_ack   = (dmem_rd_req | dmem_wr_req) && (lat_cnt == dmem_lat);
    assign dmem_rdata = dmem[dmem_addr[6:0]];

    always @(posedge clk) begin
        if ((dmem_rd_req | dmem_wr_req) && !dmem_ack) lat_cnt <= lat_cnt + 1;
        else                                          lat_cnt <= 0;
        if (dmem_rd_req) rd_cycles <= rd_cycles + 1;
        if (dmem_wr_req && dmem_ack) begin
            wr_cnt     <= wr_cnt + 1;
            last_waddr <= dmem_addr;
            last_wdata <= dmem_wdata;
        end
        if ((dmem_rd_req && dmem_wr_req) || (imem_req && (dmem_rd_req || dmem_wr_req)))
            excl_bad <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        run   = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Runs until n instructions retire, then drops run so the CPU parks in FETCH.
    task automatic run_prog(input int n, input string tag, output int cycles);
        int ret;
        ret    = 0;
        cycles = 1;
        @(negedge clk);
        run = 1'b1;
        if (retire) ret++;
        while (ret < n && cycles < 200) begin
            @(negedge clk);
            cycles++;
            if (retire) ret++;
        end
        run = 1'b0;
        if (ret < n) check({tag, "_timeout"}, 32'(ret), 32'(n));
        @(negedge clk);
    endtask

    initial begin
        int cyc;
        int wr0;
        int rd0;
        int idle_req;

        foreach (rom[i])  rom[i]  = 16'h0000;
        foreach (dmem[i]) dmem[i] = 16'h0000;
        run   = 1'b0;
        rst_n = 1'b0;
        #2;
        check("rst_imem_req", 32'(imem_req), 32'h0);
        check("rst_pc", 32'(pc), 32'h0);
        check("rst_ad", {a_reg, d_reg}, 32'h0);
        check("rst_dreq", {30'h0, dmem_rd_req, dmem_wr_req}, 32'h0);
        do_reset();

        // A-instruction then D=A
        rom[0] = 16'h0005; rom[1] = 16'hEC10;
        run_prog(2, "t1", cyc);
        check("t1_cycles", 32'(cyc), 32'd5);
        check("t1_a", 32'(a_reg), 32'd5);
        check("t1_d", 32'(d_reg), 32'd5);
        check("t1_pc", 32'(pc), 32'd2);

        // MD=D+1 with memory write
        do_reset();
        rom[0] = 16'h0007; rom[1] = 16'hEC10; rom[2] = 16'h0064; rom[3] = 16'hE7D8;
        dmem_lat = 0;
        wr0 = wr_cnt;
        run_prog(4, "t2", cyc);
        check("t2_wr_cnt", 32'(wr_cnt - wr0), 32'd1);
        check("t2_waddr", 32'(last_waddr), 32'd100);
        check("t2_wdata", 32'(last_wdata), 32'd8);
        check("t2_d", 32'(d_reg), 32'd8);
        check("t2_pc", 32'(pc), 32'd4);

        // D=M with ack delayed three cycles
        do_reset();
        rom[0] = 16'hFC10;
        dmem[0] = 16'h1234;
        dmem_lat = 3;
        rd0 = rd_cycles;
        run_prog(1, "t3", cyc);
        check("t3_rd_cycles", 32'(rd_cycles - rd0), 32'd4);
        check("t3_d", 32'(d_reg), 32'h1234);
        check("t3_cycles", 32'(cyc), 32'd7);

        // D;JEQ taken with D=0, not taken with D=1
        do_reset();
        dmem_lat = 0;
        rom[0] = 16'h000A; rom[1] = 16'hE302;
        run_prog(2, "t4a", cyc);
        check("t4_taken_pc", 32'(pc), 32'd10);
        do_reset();
        rom[0] = 16'hEFD0; rom[1] = 16'h000A; rom[2] = 16'hE302;
        run_prog(3, "t4b", cyc);
        check("t4_d1", 32'(d_reg), 32'd1);
        check("t4_fall_pc", 32'(pc), 32'd3);

        // AM=M-1 writes through the old A
        do_reset();
        rom[0] = 16'h0007; rom[1] = 16'hFCA8;
        dmem[7] = 16'd5;
        wr0 = wr_cnt;
        run_prog(2, "t5", cyc);
        check("t5_wr_cnt", 32'(wr_cnt - wr0), 32'd1);
        check("t5_waddr", 32'(last_waddr), 32'd7);
        check("t5_wdata", 32'(last_wdata), 32'd4);
        check("t5_a", 32'(a_reg), 32'd4);

        // Reset asserted in the middle of MEM_RD
        do_reset();
        rom[0] = 16'h0003; rom[1] = 16'hFC10;
        dmem_lat = 10;
        @(negedge clk);
        run = 1'b1;
        cyc = 0;
        while (!dmem_rd_req && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("t6_in_mem_rd", 32'(dmem_rd_req), 32'h1);
        check("t6_pc_before", 32'(pc), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("t6_rd_req_drop", 32'(dmem_rd_req), 32'h0);
        check("t6_imem_req_rst", 32'(imem_req), 32'h0);
        check("t6_pc_rst", 32'(pc), 32'h0);
        check("t6_a_rst", 32'(a_reg), 32'h0);
        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        dmem_lat = 0;

        // run low holds FETCH with no request
        idle_req = 0;
        repeat (5) begin
            @(negedge clk);
            if (imem_req) idle_req++;
        end
        check("t6_idle_req", 32'(idle_req), 32'h0);
        check("t6_idle_pc", 32'(pc), 32'h0);

        // PC wrap from 0x7FFF
        do_reset();
        rom[0] = 16'h7FFF; rom[1] = 16'hEA87; rom[63] = 16'h0005;
        run_prog(2, "t7a", cyc);
        check("t7_pc_max", 32'(pc), 32'h7FFF);
        run_prog(1, "t7b", cyc);
        check("t7_pc_wrap", 32'(pc), 32'h0);
        check("t7_a", 32'(a_reg), 32'd5);

        check("req_exclusive", 32'(excl_bad), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
